// File: rtl/instr_rom_loader_pkg.sv
// Shared types and helpers for the instruction ROM loader: FSM states,
// stream framing constants and big-endian word assembly.
package loader_pkg;

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_RUN,
    S_ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // First byte of the stream lands in the most significant lane.
  function automatic logic [31:0] be_pack(input byte b [4]);
    return {b[0], b[1], b[2], b[3]};
  endfunction

endpackage

// File: rtl/instr_rom_loader_ram.sv
// Instruction word RAM: one synchronous write port, one registered read port.
module instr_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset so it maps onto block RAM; stale words are
  // hidden by the fetch gating in the top level instead.
  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_rom_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction RAM, holds
// the core in reset until the load completes, then serves fetches.
module instr_rom_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        LoadData,
  input  logic              LoadValid,
  output logic              LoadReady,
  input  logic [ADDR_W-1:0] InstrAddr,
  output logic [31:0]       InstrMem,
  output logic              CoreNReset,
  output logic              Done,
  output logic              Error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  loader_state_t     state;
  logic [15:0]       n_words;
  logic [AW:0]       word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_q;
  logic [15:0]       hdr_n;
  logic              accept;
  logic              last_byte;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [ADDR_W-3:0] widx;
  logic              fetch_ok;
  logic              fetch_ok_q;
  logic [1:0]        unused_addr_bits;
  byte               pack_in [4];

  assign LoadReady = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_DATA);
  assign Done      = (state == S_RUN);
  assign Error     = (state == S_ERR);

  assign accept    = LoadValid && LoadReady;
  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign ram_we    = accept && (state == S_DATA) && last_byte;
  assign hdr_n     = {n_words[15:8], LoadData};

  // NOTE: every variable written in always_comb is assigned on every pass,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pack_in[0] = byte'(shift_q[23:16]);
    pack_in[1] = byte'(shift_q[15:8]);
    pack_in[2] = byte'(shift_q[7:0]);
    pack_in[3] = byte'(LoadData);
  end

  assign ram_wdata = be_pack(pack_in);

  // Byte lanes inside a word are irrelevant to a word-wide fetch.
  assign widx             = InstrAddr[ADDR_W-1:2];
  assign unused_addr_bits = InstrAddr[1:0];
  assign fetch_ok         = Done && (32'(widx) < 32'(n_words));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_HDR_HI;
      n_words  <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        S_HDR_HI: begin
          if (accept) begin
            n_words[15:8] <= LoadData;
            state         <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            n_words[7:0] <= LoadData;
            if (hdr_n == 16'd0)                    state <= S_RUN;
            else if (32'(hdr_n) > DEPTH_WORDS)     state <= S_ERR;
            else                                   state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              word_idx <= word_idx + 1'b1;
              if (32'(word_idx) == 32'(n_words) - 32'd1) state <= S_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte assembly register is pure datapath; its contents are only consumed
  // together with byte_cnt, which does reset.
  always_ff @(posedge Clock) begin
    if (accept && (state == S_DATA)) shift_q <= {shift_q[15:0], LoadData};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      CoreNReset <= 1'b0;
      fetch_ok_q <= 1'b0;
    end else begin
      CoreNReset <= (state == S_RUN);
      fetch_ok_q <= fetch_ok;
    end
  end

  instr_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .Clock (Clock),
    .we    (ram_we),
    .waddr (word_idx[AW-1:0]),
    .wdata (ram_wdata),
    .raddr (AW'(widx)),
    .rdata (ram_rdata)
  );

  // The gate is registered alongside the RAM read so both describe the same edge.
  assign InstrMem = fetch_ok_q ? ram_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Self-checking bench for instr_rom_loader: stream-level reference model with
// per-cycle comparison, directed scenarios and randomized loads.
module tb_instr_rom_loader;

  localparam int DEPTH = 1024;

  logic        Clock     = 1'b0;
  logic        Reset     = 1'b1;
  logic [7:0]  LoadData  = 8'hFF;
  logic        LoadValid = 1'b0;
  logic [15:0] InstrAddr = 16'h0000;
  logic        LoadReady;
  logic [31:0] InstrMem;
  logic        CoreNReset;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  instr_rom_loader #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (16)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .LoadData   (LoadData),
    .LoadValid  (LoadValid),
    .LoadReady  (LoadReady),
    .InstrAddr  (InstrAddr),
    .InstrMem   (InstrMem),
    .CoreNReset (CoreNReset),
    .Done       (Done),
    .Error      (Error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the accepted byte stream since the last reset.
  logic [7:0]  q [$];
  bit          model_valid = 1'b0;
  logic [31:0] exp_instr;
  logic        exp_cnr, exp_done, exp_err, exp_ready;

  function automatic int m_n();
    if (q.size() < 2) return -1;
    return int'({q[0], q[1]});
  endfunction

  function automatic bit m_err();
    return m_n() > DEPTH;
  endfunction

  function automatic bit m_done();
    int n = m_n();
    if (n < 0 || n > DEPTH) return 1'b0;
    return ((q.size() - 2) / 4) >= n;
  endfunction

  function automatic logic [31:0] m_fetch(input logic [15:0] a);
    int w = int'(a[15:2]);
    if (!m_done() || w >= m_n()) return 32'h0;
    return {q[2+4*w], q[3+4*w], q[4+4*w], q[5+4*w]};
  endfunction

  always @(posedge Clock) begin
    bit ready_before;
    ready_before = !m_done() && !m_err();
    exp_instr    = m_fetch(InstrAddr);
    exp_cnr      = m_done();
    if (Reset) begin
      q.delete();
      exp_instr   = 32'h0;
      exp_cnr     = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid && ready_before && LoadValid) begin
      q.push_back(LoadData);
    end
    exp_done  = m_done();
    exp_err   = m_err();
    exp_ready = !exp_done && !exp_err;
  end

  always @(negedge Clock) begin
    if (model_valid) begin
      check("LoadReady",  LoadReady,  exp_ready);
      check("Done",       Done,       exp_done);
      check("Error",      Error,      exp_err);
      check("CoreNReset", CoreNReset, exp_cnr);
      check("InstrMem",   InstrMem,   exp_instr);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    LoadValid = 1'b0;
    LoadData  = 8'hFF;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bubble);
    if (bubble) begin
      LoadValid = 1'b0;
      LoadData  = 8'hFF;
      tick();
    end
    LoadValid = 1'b1;
    LoadData  = b;
    tick();
    LoadValid = 1'b0;
    LoadData  = 8'hFF;
  endtask

  task automatic fetch(input logic [15:0] a, output logic [31:0] d);
    InstrAddr = a;
    tick();
    d = InstrMem;
  endtask

  logic [7:0]  prog1 [14] = '{8'h00, 8'h03, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h34,
                              8'h21, 8'h56, 8'h78, 8'h3C, 8'h02, 8'h55, 8'h55};
  logic [31:0] d;

  initial begin
    do_reset();

    // Scenario 1: back-to-back three-word load.
    for (int i = 0; i < 14; i++) begin
      send_byte(prog1[i], 1'b0);
      if (i == 12) check("s1_done_before_last", Done, 1'b0);
    end
    check("s1_done_after_last", Done, 1'b1);
    check("s1_ready_after_last", LoadReady, 1'b0);
    check("s1_cnr_same_cycle", CoreNReset, 1'b0);
    tick();
    check("s1_cnr_next_cycle", CoreNReset, 1'b1);
    fetch(16'h0004, d); check("s1_fetch_4", d, 32'h3421_5678);
    fetch(16'h000C, d); check("s1_fetch_c", d, 32'h0);
    fetch(16'h0006, d); check("s6_fetch_unaligned", d, 32'h3421_5678);
    fetch(16'h0000, d); check("s1_fetch_0", d, 32'h3C01_1234);

    // Scenario 6: reset while running.
    Reset = 1'b1;
    tick();
    check("s6_cnr_reset", CoreNReset, 1'b0);
    check("s6_done_reset", Done, 1'b0);
    check("s6_instr_reset", InstrMem, 32'h0);
    Reset = 1'b0;

    // Scenario 2: bubbles with 0xFF on the idle data lines.
    for (int i = 0; i < 14; i++) send_byte(prog1[i], 1'b1);
    tick();
    fetch(16'h0000, d); check("s2_fetch_0", d, 32'h3C01_1234);
    fetch(16'h0004, d); check("s2_fetch_4", d, 32'h3421_5678);
    fetch(16'h0008, d); check("s2_fetch_8", d, 32'h3C02_5555);
    fetch(16'h000C, d); check("s2_fetch_c", d, 32'h0);

    // Scenario 3: word count one beyond capacity.
    do_reset();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    check("s3_error", Error, 1'b1);
    check("s3_ready", LoadReady, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0);
    check("s3_cnr", CoreNReset, 1'b0);
    fetch(16'h0000, d); check("s3_fetch_0", d, 32'h0);

    // Scenario 4: empty program.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("s4_done", Done, 1'b1);
    tick();
    fetch(16'h0000, d); check("s4_fetch_0", d, 32'h0);

    // Scenario 5: abort mid-load, then reload one word.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h41, 1'b0);
    send_byte(8'h18, 1'b0); send_byte(8'h20, 1'b0);
    tick();
    fetch(16'h0000, d); check("s5_fetch_0", d, 32'h0041_1820);
    fetch(16'h0004, d); check("s5_fetch_4", d, 32'h0);

    // Boundary: exactly full RAM.
    do_reset();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'($urandom), 1'b0);
    check("full_done", Done, 1'b1);
    tick();
    fetch(16'(4 * (DEPTH - 1)), d);
    fetch(16'(4 * DEPTH), d); check("full_fetch_beyond", d, 32'h0);
    fetch(16'hFFFC, d);       check("full_fetch_top", d, 32'h0);

    // Randomized loads, bubbles, aborts and fetches against the model.
    for (int iter = 0; iter < 30; iter++) begin
      int n;
      bit aborted;
      do_reset();
      n = $urandom_range(0, 8);
      if ($urandom_range(0, 7) == 0) n = $urandom_range(DEPTH + 1, 16'hFFFF);
      send_byte(8'(n >> 8), 1'($urandom_range(0, 1)));
      send_byte(8'(n),      1'($urandom_range(0, 1)));
      aborted = 1'b0;
      if (n <= DEPTH) begin
        for (int i = 0; i < 4 * n; i++) begin
          if ($urandom_range(0, 40) == 0) begin
            aborted = 1'b1;
            do_reset();
            break;
          end
          send_byte(8'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      if (aborted) send_byte(8'($urandom), 1'b0);
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 3) == 0) fetch(16'($urandom), d);
        else fetch(16'($urandom_range(0, 4 * 10 + 3)), d);
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_rom_loader.md
# instr_rom_loader

Instruction memory with a byte-stream program loader that sits on the processor's instruction fetch port (`InstrAddr` → `InstrMem`). It accepts a length-prefixed byte stream and writes it into an internal word RAM. The core is held in reset until loading completes. After that it serves instruction fetches with one-cycle registered latency. Fetches beyond the loaded program return `32'h00000000` (NOP).

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: instruction RAM depth in 32-bit words (power of two, ≤ 16384).
- `ADDR_W`, 16: width of the fetch byte address.

Ports:
- `Clock`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `LoadData`, in, 8: loader stream byte.
- `LoadValid`, in, 1: `LoadData` is valid.
- `LoadReady`, out, 1: loader accepts a byte this cycle.
- `InstrAddr`, in, `ADDR_W`: fetch byte address from the core. Bits [1:0] are ignored.
- `InstrMem`, out, 32: fetched instruction word.
- `CoreNReset`, out, 1: active-low reset to the processor (drives its `nReset`).
- `Done`, out, 1: program loaded; block is in RUN.
- `Error`, out, 1: header word count exceeded `DEPTH_WORDS`.

## Operation
- A byte is accepted on a rising edge with `LoadValid && LoadReady`. `LoadData` is ignored at all other times.
- Stream format:
  - Two-byte big-endian word count N.
  - Then 4N bytes, each word big-endian (first byte goes to [31:24]).
- FSM states: `S_HDR_HI`, `S_HDR_LO`, `S_DATA`, `S_RUN`, `S_ERR`. Reset state is `S_HDR_HI`.
  - `S_HDR_HI`: on accept, latch N[15:8], go to `S_HDR_LO`.
  - `S_HDR_LO`: on accept, latch N[7:0], then go to:
    - `S_RUN` if N == 0;
    - `S_ERR` if N > `DEPTH_WORDS`;
    - otherwise `S_DATA`.
  - `S_DATA`: a 2-bit byte counter assembles bytes into a word. On the 4th byte's accept, write the word to RAM[`word_idx`] and increment `word_idx`. If `word_idx` == N−1 at that accept, go to `S_RUN`.
  - `S_RUN`: terminal until `Reset`. No writes.
  - `S_ERR`: terminal until `Reset`. No writes.
- `LoadReady` is 1 in `S_HDR_HI`, `S_HDR_LO` and `S_DATA`. It is 0 in `S_RUN` and `S_ERR`.
- `Done` = (state == `S_RUN`). `Error` = (state == `S_ERR`). Both decode directly from the state register.
- `CoreNReset` is registered: it loads (state == `S_RUN`) each edge and is forced to 0 by `Reset`.
- Fetch, evaluated every edge:
  - Let `widx` = `InstrAddr[ADDR_W-1:2]`.
  - `InstrMem` <= RAM[`widx`] if state == `S_RUN` and `widx` < N.
  - Otherwise `InstrMem` <= 0, including `widx` ≥ `DEPTH_WORDS`.
- Widths:
  - N is 16 bits.
  - `word_idx` is `$clog2(DEPTH_WORDS)+1` bits and never wraps, because N ≤ `DEPTH_WORDS` is enforced.
- Reset mid-load: state, N, `word_idx` and the byte counter clear. RAM contents are retained but unreachable, since N = 0 forces 0 reads. A reload overwrites them.
- Simultaneous accept and `Reset`: `Reset` wins and the byte is dropped.

## Timing
- Reset values:
  - `LoadReady` = 1, `InstrMem` = 0, `CoreNReset` = 0, `Done` = 0, `Error` = 0.
  - Internal: N = 0, `word_idx` = 0, byte counter = 0.
- Final byte accepted at edge k:
  - `Done` = 1 and `LoadReady` = 0 after edge k.
  - `CoreNReset` = 1 after edge k+1.
  - The core's first fetch is therefore one cycle after `Done`.
- Fetch latency: `InstrAddr` sampled at edge t gives `InstrMem` valid after edge t, stable until edge t+1.
- RAM write: committed at the 4th-byte edge. Readable from the next edge, which is always in `S_RUN` or later.
- Maximum throughput: one byte per cycle. `LoadReady` never drops inside `S_DATA`.

## Structure
- `loader_pkg`:
  - `loader_state_t` enum for the five states.
  - `HDR_BYTES` = 2.
  - `BYTES_PER_WORD` = 4.
  - Function `be_pack(byte b[4])` returning logic [31:0].
- Sub-module `instr_ram`:
  - `DEPTH_WORDS` x 32.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - One synchronous registered read port (`raddr`, `rdata`).
  - No reset on the array.
- The top level holds the FSM, counters, N register, the `widx` < N / RUN gating mux, and the `CoreNReset` flop.

## Test plan
1. Load N=0x0003 with words `3C011234`, `34215678`, `3C025555`, one byte per cycle:
   - `Done` rises 2+12 accepts after reset, and `CoreNReset` rises the following cycle.
   - `InstrAddr`=0x0004 → `InstrMem`=`34215678`.
   - `InstrAddr`=0x000C → 0.
2. Bubbles: as scenario 1, but `LoadValid` low on alternate cycles and `LoadData`=0xFF while invalid. The same RAM contents result, with no extra words.
3. Header N=0x0401 with `DEPTH_WORDS`=1024:
   - `Error`=1 and `LoadReady`=0 after the second byte.
   - `CoreNReset` stays 0, and `InstrMem`=0 for any address.
4. Header N=0x0000: `Done`=1 immediately after the header. All fetches return 0.
5. `Reset` asserted after 6 data bytes of an N=2 load, then a fresh N=1 load of `00411820`:
   - `InstrMem`=`00411820` at address 0.
   - Address 4 returns 0, even though the old RAM word is stale.
6. Unaligned fetch: `InstrAddr`=0x0006 after scenario 1 → `34215678`. `Reset` during `S_RUN` → `CoreNReset`=0, `Done`=0, `InstrMem`=0 next cycle.
